// File: rtl/exe_unit_arbiter.sv
// exe_unit_arbiter
// Shares a single execution unit (subtract / compare / shift / bit-change)
// between two requesters. Commands are granted round-robin, held on the unit's
// inputs for its result latency, and the captured result and status are
// returned with the requester ID on a valid/ready response channel.
//
// Optional feature: define EXE_ARB_STICKY_STATUS_EN to add per-requester
// sticky status registers (o_sticky0/o_sticky1) with a shared clear
// (i_sticky_clr).

module exe_unit_arbiter #(
  parameter int BITS    = 8,
  parameter int LATENCY = 1
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_req0_valid,
  output logic            o_req0_ready,
  input  logic [BITS-1:0] i_req0_a,
  input  logic [BITS-1:0] i_req0_b,
  input  logic [1:0]      i_req0_op,
  input  logic            i_req1_valid,
  output logic            o_req1_ready,
  input  logic [BITS-1:0] i_req1_a,
  input  logic [BITS-1:0] i_req1_b,
  input  logic [1:0]      i_req1_op,
  output logic [BITS-1:0] o_exe_a,
  output logic [BITS-1:0] o_exe_b,
  output logic [1:0]      o_exe_op,
  input  logic [BITS-1:0] i_exe_out,
  input  logic [3:0]      i_exe_status,
  output logic            o_rsp_valid,
  input  logic            i_rsp_ready,
  output logic            o_rsp_id,
  output logic [BITS-1:0] o_rsp_out,
  output logic [3:0]      o_rsp_status
`ifdef EXE_ARB_STICKY_STATUS_EN
  ,
  input  logic            i_sticky_clr,
  output logic [3:0]      o_sticky0,
  output logic [3:0]      o_sticky1
`endif
);

  // The wait counter is 4 bits wide, which covers latencies 0..15.
  localparam logic [3:0] LAT_LOAD = 4'(LATENCY);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t          r_state;
  state_t          w_nextState;

  logic            r_rrPtr;
  logic            r_grantId;
  logic [3:0]      r_count;
  logic [BITS-1:0] r_exeA;
  logic [BITS-1:0] r_exeB;
  logic [1:0]      r_exeOp;
  logic            r_rspId;
  logic [BITS-1:0] r_rspOut;
  logic [3:0]      r_rspStatus;

  logic            w_anyValid;
  logic            w_grantId;
  logic            w_accept;
  logic            w_capture;

  // Grant selection: a lone requester always wins, a tie goes to the rr pointer.
  always_comb begin
    w_grantId = 1'b0;
    if (i_req0_valid && i_req1_valid) begin
      w_grantId = r_rrPtr;
    end else if (i_req1_valid) begin
      w_grantId = 1'b1;
    end
  end

  assign w_anyValid = i_req0_valid | i_req1_valid;
  assign w_accept   = (r_state == S_IDLE) && w_anyValid;
  assign w_capture  = (r_state == S_WAIT) && (r_count == 4'd0);

  // Next-state logic plus the handshake outputs that depend only on state and grant.
  always_comb begin
    w_nextState  = r_state;
    o_req0_ready = 1'b0;
    o_req1_ready = 1'b0;
    o_rsp_valid  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_anyValid) begin
          o_req0_ready = ~w_grantId;
          o_req1_ready = w_grantId;
          w_nextState  = S_WAIT;
        end
      end
      S_WAIT: begin
        if (r_count == 4'd0) begin
          w_nextState = S_RESP;
        end
      end
      S_RESP: begin
        o_rsp_valid = 1'b1;
        if (i_rsp_ready) begin
          w_nextState = S_IDLE;
        end
      end
      default: begin
        w_nextState = S_IDLE;
      end
    endcase
  end

  // State register; reset abandons any command in flight.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Latch the granted command onto the unit inputs and count down its latency.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_exeA    <= '0;
      r_exeB    <= '0;
      r_exeOp   <= 2'b00;
      r_grantId <= 1'b0;
      r_count   <= 4'd0;
    end else if (w_accept) begin
      r_exeA    <= w_grantId ? i_req1_a  : i_req0_a;
      r_exeB    <= w_grantId ? i_req1_b  : i_req0_b;
      r_exeOp   <= w_grantId ? i_req1_op : i_req0_op;
      r_grantId <= w_grantId;
      r_count   <= LAT_LOAD;
    end else if ((r_state == S_WAIT) && (r_count != 4'd0)) begin
      r_count <= r_count - 4'd1;
    end
  end

  // Capture the unit result once the latency has elapsed; held until the next capture.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rspId     <= 1'b0;
      r_rspOut    <= '0;
      r_rspStatus <= 4'd0;
    end else if (w_capture) begin
      r_rspId     <= r_grantId;
      r_rspOut    <= i_exe_out;
      r_rspStatus <= i_exe_status;
    end
  end

  // Round-robin pointer favours the other requester once a response is consumed.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rrPtr <= 1'b0;
    end else if ((r_state == S_RESP) && i_rsp_ready) begin
      r_rrPtr <= ~r_rspId;
    end
  end

  assign o_exe_a      = r_exeA;
  assign o_exe_b      = r_exeB;
  assign o_exe_op     = r_exeOp;
  assign o_rsp_id     = r_rspId;
  assign o_rsp_out    = r_rspOut;
  assign o_rsp_status = r_rspStatus;

`ifdef EXE_ARB_STICKY_STATUS_EN
  logic [3:0] r_sticky0;
  logic [3:0] r_sticky1;

  // Accumulate status per requester; a clear coinciding with a capture keeps only the new status.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sticky0 <= 4'd0;
      r_sticky1 <= 4'd0;
    end else if (i_sticky_clr) begin
      r_sticky0 <= (w_capture && !r_grantId) ? i_exe_status : 4'd0;
      r_sticky1 <= (w_capture &&  r_grantId) ? i_exe_status : 4'd0;
    end else if (w_capture) begin
      if (r_grantId) begin
        r_sticky1 <= r_sticky1 | i_exe_status;
      end else begin
        r_sticky0 <= r_sticky0 | i_exe_status;
      end
    end
  end

  assign o_sticky0 = r_sticky0;
  assign o_sticky1 = r_sticky1;
`endif

endmodule

// File: tb/tb_exe_unit_arbiter.sv
// tb_exe_unit_arbiter
// Directed bench for exe_unit_arbiter. Two instances are exercised: one with
// LATENCY=1 and one with LATENCY=3, each connected to a small behavioural
// execution unit whose result appears LATENCY edges after its operands.
// Sticky-status checks are compiled in when EXE_ARB_STICKY_STATUS_EN is defined.

module tb_exe_unit_arbiter;

  logic clk;
  logic rst;

  int vectors;
  int miscompares;

  // LATENCY=1 instance signals
  logic       v0, v1, r0Ready, r1Ready;
  logic [7:0] a0, b0, a1, b1;
  logic [1:0] op0, op1;
  logic [7:0] exeA, exeB, exeOut;
  logic [1:0] exeOp;
  logic [3:0] exeStatus;
  logic       rspValid, rspReady, rspId;
  logic [7:0] rspOut;
  logic [3:0] rspStatus;

  // LATENCY=3 instance signals
  logic       l3V0, l3V1, l3Rdy0, l3Rdy1;
  logic [7:0] l3A0, l3B0, l3A1, l3B1;
  logic [1:0] l3Op0, l3Op1;
  logic [7:0] l3ExeA, l3ExeB, l3ExeOut;
  logic [1:0] l3ExeOp;
  logic [3:0] l3ExeStatus;
  logic       l3RspValid, l3RspReady, l3RspId;
  logic [7:0] l3RspOut;
  logic [3:0] l3RspStatus;

`ifdef EXE_ARB_STICKY_STATUS_EN
  logic       stickyClr, l3StickyClr;
  logic [3:0] d1Sticky0, d1Sticky1, l3Sticky0, l3Sticky1;
`endif

  exe_unit_arbiter #(.BITS(8), .LATENCY(1)) dut1 (
    .i_clk(clk), .i_rst(rst),
    .i_req0_valid(v0), .o_req0_ready(r0Ready), .i_req0_a(a0), .i_req0_b(b0), .i_req0_op(op0),
    .i_req1_valid(v1), .o_req1_ready(r1Ready), .i_req1_a(a1), .i_req1_b(b1), .i_req1_op(op1),
    .o_exe_a(exeA), .o_exe_b(exeB), .o_exe_op(exeOp),
    .i_exe_out(exeOut), .i_exe_status(exeStatus),
    .o_rsp_valid(rspValid), .i_rsp_ready(rspReady), .o_rsp_id(rspId),
    .o_rsp_out(rspOut), .o_rsp_status(rspStatus)
`ifdef EXE_ARB_STICKY_STATUS_EN
    , .i_sticky_clr(stickyClr), .o_sticky0(d1Sticky0), .o_sticky1(d1Sticky1)
`endif
  );

  exe_unit_arbiter #(.BITS(8), .LATENCY(3)) dut3 (
    .i_clk(clk), .i_rst(rst),
    .i_req0_valid(l3V0), .o_req0_ready(l3Rdy0), .i_req0_a(l3A0), .i_req0_b(l3B0), .i_req0_op(l3Op0),
    .i_req1_valid(l3V1), .o_req1_ready(l3Rdy1), .i_req1_a(l3A1), .i_req1_b(l3B1), .i_req1_op(l3Op1),
    .o_exe_a(l3ExeA), .o_exe_b(l3ExeB), .o_exe_op(l3ExeOp),
    .i_exe_out(l3ExeOut), .i_exe_status(l3ExeStatus),
    .o_rsp_valid(l3RspValid), .i_rsp_ready(l3RspReady), .o_rsp_id(l3RspId),
    .o_rsp_out(l3RspOut), .o_rsp_status(l3RspStatus)
`ifdef EXE_ARB_STICKY_STATUS_EN
    , .i_sticky_clr(l3StickyClr), .o_sticky0(l3Sticky0), .o_sticky1(l3Sticky1)
`endif
  );

  // Behavioural unit: {zero, msb, a<b, parity, result}
  function automatic logic [11:0] fModel(input logic [7:0] a, input logic [7:0] b, input logic [1:0] op);
    logic [7:0] r;
    case (op)
      2'b00:   r = a - b;
      2'b01:   r = {7'd0, (a < b)};
      2'b10:   r = a >> b[2:0];
      default: r = a ^ (8'h01 << b[2:0]);
    endcase
    return {(r == 8'd0), r[7], (a < b), ^r, r};
  endfunction

  // Unit model pipelines, one register stage per edge of latency
  logic [11:0] d1Pipe;
  logic [11:0] l3Pipe [0:2];

  always @(posedge clk) begin
    d1Pipe    <= fModel(exeA, exeB, exeOp);
    l3Pipe[0] <= fModel(l3ExeA, l3ExeB, l3ExeOp);
    l3Pipe[1] <= l3Pipe[0];
    l3Pipe[2] <= l3Pipe[1];
  end

  assign exeOut      = d1Pipe[7:0];
  assign exeStatus   = d1Pipe[11:8];
  assign l3ExeOut    = l3Pipe[2][7:0];
  assign l3ExeStatus = l3Pipe[2][11:8];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic iv0, input logic [7:0] ia0, input logic [7:0] ib0, input logic [1:0] iop0,
                               input logic iv1, input logic [7:0] ia1, input logic [7:0] ib1, input logic [1:0] iop1);
    v0 = iv0; a0 = ia0; b0 = ib0; op0 = iop0;
    v1 = iv1; a1 = ia1; b1 = ib1; op1 = iop1;
  endtask

  // Wait (bounded) for the LATENCY=1 response valid
  task automatic waitRsp(input string tag);
    logic seen;
    seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      tick();
      if (rspValid) seen = 1'b1;
    end
    checkOutput(tag, {31'd0, seen}, 32'd1);
  endtask

  // Issue one req0 command to the LATENCY=3 instance and measure the edges to response
  task automatic l3Command(input string tag, input logic [7:0] a, input logic [7:0] b, input logic [1:0] op,
                           input logic [7:0] expOut, input logic [3:0] expStatus);
    int edges;
    logic seen;
    l3V0 = 1'b1; l3A0 = a; l3B0 = b; l3Op0 = op;
    #1;
    checkOutput({tag, "_ready"}, {31'd0, l3Rdy0}, 32'd1);
    tick();
    l3V0 = 1'b0;
    edges = 0;
    seen  = 1'b0;
    for (int c = 0; c < 8 && !seen; c++) begin
      tick();
      edges++;
      if (l3RspValid) seen = 1'b1;
    end
    checkOutput({tag, "_latency"}, edges, 32'd4);
    checkOutput({tag, "_out"}, {24'd0, l3RspOut}, {24'd0, expOut});
    checkOutput({tag, "_status"}, {28'd0, l3RspStatus}, {28'd0, expStatus});
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic anySeen;
    vectors = 0;
    miscompares = 0;
    rst = 1'b1;
    applyStimulus(1'b0, 8'd0, 8'd0, 2'b00, 1'b0, 8'd0, 8'd0, 2'b00);
    rspReady = 1'b0;
    l3V0 = 1'b0; l3A0 = 8'd0; l3B0 = 8'd0; l3Op0 = 2'b00;
    l3V1 = 1'b0; l3A1 = 8'd0; l3B1 = 8'd0; l3Op1 = 2'b00;
    l3RspReady = 1'b1;
`ifdef EXE_ARB_STICKY_STATUS_EN
    stickyClr = 1'b0;
    l3StickyClr = 1'b0;
`endif
    d1Pipe = 12'd0;

    // Reset state
    #12;
    checkOutput("rst_rsp_valid", {31'd0, rspValid}, 32'd0);
    checkOutput("rst_rsp_id", {31'd0, rspId}, 32'd0);
    checkOutput("rst_rsp_out", {24'd0, rspOut}, 32'd0);
    checkOutput("rst_rsp_status", {28'd0, rspStatus}, 32'd0);
    checkOutput("rst_exe", {14'd0, exeA, exeB, exeOp}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    tick();

    // Single request, LATENCY=1: 91-41=50
    applyStimulus(1'b1, 8'd91, 8'd41, 2'b00, 1'b0, 8'd0, 8'd0, 2'b00);
    #1;
    checkOutput("single_r0_ready", {31'd0, r0Ready}, 32'd1);
    checkOutput("single_r1_ready", {31'd0, r1Ready}, 32'd0);
    tick();
    v0 = 1'b0;
    checkOutput("single_exe", {14'd0, exeA, exeB, exeOp}, {14'd0, 8'd91, 8'd41, 2'b00});
    checkOutput("single_wait0", {31'd0, rspValid}, 32'd0);
    tick();
    checkOutput("single_wait1", {31'd0, rspValid}, 32'd0);
    tick();
    checkOutput("single_valid", {31'd0, rspValid}, 32'd1);
    checkOutput("single_id", {31'd0, rspId}, 32'd0);
    checkOutput("single_out", {24'd0, rspOut}, 32'd50);
    checkOutput("single_status", {28'd0, rspStatus}, 32'h1);
    rspReady = 1'b1;
    tick();
    checkOutput("single_done", {31'd0, rspValid}, 32'd0);

    // Reset pulse between edges, so the rr pointer starts at 0 again
    rst = 1'b1;
    #2;
    rst = 1'b0;
    tick();

    // Simultaneous requests: req0 first, then req1 (110-11=99)
    applyStimulus(1'b1, 8'd90, 8'd40, 2'b01, 1'b1, 8'd110, 8'd11, 2'b00);
    #1;
    checkOutput("sim_r0_ready", {31'd0, r0Ready}, 32'd1);
    checkOutput("sim_r1_ready", {31'd0, r1Ready}, 32'd0);
    tick();
    v0 = 1'b0;
    checkOutput("sim_exe_a", {24'd0, exeA}, 32'd90);
    checkOutput("sim_wait_r1_ready", {31'd0, r1Ready}, 32'd0);
    tick();
    tick();
    checkOutput("sim_rsp0_valid", {31'd0, rspValid}, 32'd1);
    checkOutput("sim_rsp0_id", {31'd0, rspId}, 32'd0);
    checkOutput("sim_rsp0_out", {24'd0, rspOut}, 32'd0);
    checkOutput("sim_rsp0_status", {28'd0, rspStatus}, 32'h8);
    checkOutput("sim_resp_r1_ready", {31'd0, r1Ready}, 32'd0);
    tick();
    checkOutput("sim_idle_r1_ready", {31'd0, r1Ready}, 32'd1);
    rspReady = 1'b0;
    tick();
    checkOutput("sim_exe_a1", {24'd0, exeA}, 32'd110);
    applyStimulus(1'b0, 8'd0, 8'd0, 2'b00, 1'b1, 8'h80, 8'd3, 2'b10);
    tick();
    tick();

    // Back-pressure: response held for 5 cycles, req1 kept waiting
    for (int i = 0; i < 5; i++) begin
      checkOutput("bp_valid", {31'd0, rspValid}, 32'd1);
      checkOutput("bp_id", {31'd0, rspId}, 32'd1);
      checkOutput("bp_out", {24'd0, rspOut}, 32'd99);
      checkOutput("bp_status", {28'd0, rspStatus}, 32'h0);
      checkOutput("bp_r1_ready", {31'd0, r1Ready}, 32'd0);
      tick();
    end
    rspReady = 1'b1;
    #1;
    checkOutput("bp_r1_ready_last", {31'd0, r1Ready}, 32'd0);
    tick();
    checkOutput("bp_idle_r1_ready", {31'd0, r1Ready}, 32'd1);
    tick();
    v1 = 1'b0;
    waitRsp("bp_next_seen");
    checkOutput("bp_next_id", {31'd0, rspId}, 32'd1);
    checkOutput("bp_next_out", {24'd0, rspOut}, 32'h10);
    checkOutput("bp_next_status", {28'd0, rspStatus}, 32'h1);
    tick();

    // Fairness: both continuously valid, IDs must alternate 0,1,0,1,0,1
    applyStimulus(1'b1, 8'd20, 8'd5, 2'b00, 1'b1, 8'd0, 8'd2, 2'b11);
    for (int k = 0; k < 6; k++) begin
      waitRsp("fair_seen");
      checkOutput("fair_id", {31'd0, rspId}, k % 2);
      checkOutput("fair_out", {24'd0, rspOut}, (k % 2 == 0) ? 32'd15 : 32'd4);
      checkOutput("fair_status", {28'd0, rspStatus}, (k % 2 == 0) ? 32'h0 : 32'h3);
      tick();
    end
    applyStimulus(1'b0, 8'd0, 8'd0, 2'b00, 1'b0, 8'd0, 8'd0, 2'b00);

    // Reset mid-operation during WAIT
    applyStimulus(1'b1, 8'd7, 8'd2, 2'b00, 1'b0, 8'd0, 8'd0, 2'b00);
    tick();
    v0 = 1'b0;
    checkOutput("mid_exe_a", {24'd0, exeA}, 32'd7);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("mid_rst_exe", {14'd0, exeA, exeB, exeOp}, 32'd0);
    checkOutput("mid_rst_valid", {31'd0, rspValid}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    anySeen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (rspValid) anySeen = 1'b1;
    end
    checkOutput("mid_no_rsp", {31'd0, anySeen}, 32'd0);
    applyStimulus(1'b0, 8'd0, 8'd0, 2'b00, 1'b1, 8'd9, 8'd4, 2'b00);
    #1;
    checkOutput("mid_r1_ready", {31'd0, r1Ready}, 32'd1);
    tick();
    v1 = 1'b0;
    waitRsp("mid_seen");
    checkOutput("mid_id", {31'd0, rspId}, 32'd1);
    checkOutput("mid_out", {24'd0, rspOut}, 32'd5);
    tick();

    // LATENCY=3 instance: three commands from req0, sticky clear between 2nd and 3rd
    l3Command("l3_c1", 8'd5, 8'd9, 2'b00, 8'hFC, 4'h6);
    tick();
    l3Command("l3_c2", 8'h10, 8'h10, 2'b00, 8'h00, 4'h8);
`ifdef EXE_ARB_STICKY_STATUS_EN
    checkOutput("l3_sticky0_or", {28'd0, l3Sticky0}, 32'hE);
    checkOutput("l3_sticky1_idle", {28'd0, l3Sticky1}, 32'h0);
`endif
    tick();
`ifdef EXE_ARB_STICKY_STATUS_EN
    l3StickyClr = 1'b1;
    tick();
    l3StickyClr = 1'b0;
    checkOutput("l3_sticky0_clr", {28'd0, l3Sticky0}, 32'h0);
`endif
    l3Command("l3_c3", 8'd3, 8'd1, 2'b00, 8'h02, 4'h1);
`ifdef EXE_ARB_STICKY_STATUS_EN
    checkOutput("l3_sticky0_new", {28'd0, l3Sticky0}, 32'h1);
    checkOutput("l3_sticky1_new", {28'd0, l3Sticky1}, 32'h0);
`endif
    tick();
    checkOutput("l3_done", {31'd0, l3RspValid}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
